// File: rtl/xbus_arbiter.sv
// Registered round-robin bus arbiter: m1 (fetch) is the parked default owner,
// m0/m2/m3 share the bus round-robin with a bounded hold time under contention.
module xbus_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req_i,
  output logic [3:0] grant_o,
  output logic [1:0] owner_o,
  output logic       hold_o,
  output logic       switch_o
);

  typedef enum logic {IDLE, OWN} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  state_t           r_state, w_state_next;
  logic [3:0]       r_grant, w_grant_next;
  logic [1:0]       r_owner, w_owner_next;
  logic [1:0]       r_rr_ptr, w_rr_ptr_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             r_switch, w_switch_next;

  logic [3:0]       w_others;
  logic [2:0]       w_cand;
  logic             w_found;
  logic [1:0]       w_pick;

  function automatic logic [1:0] succ(input logic [1:0] k);
    case (k)
      2'd0:    succ = 2'd2;
      2'd2:    succ = 2'd3;
      default: succ = 2'd0;
    endcase
  endfunction

  // Eligible requesters other than the current owner; positions 0/1/2 = m0/m2/m3.
  always_comb begin
    w_others = {req_i[3], req_i[2], 1'b0, req_i[0]};
    if (r_state == OWN) begin
      w_others[r_owner] = 1'b0;
    end
    w_cand  = {w_others[3], w_others[2], w_others[0]};
    w_found = |w_cand;
    w_pick  = 2'd1;
    case (r_rr_ptr)
      2'd2: begin
        if (w_cand[1])      w_pick = 2'd2;
        else if (w_cand[2]) w_pick = 2'd3;
        else if (w_cand[0]) w_pick = 2'd0;
      end
      2'd3: begin
        if (w_cand[2])      w_pick = 2'd3;
        else if (w_cand[0]) w_pick = 2'd0;
        else if (w_cand[1]) w_pick = 2'd2;
      end
      default: begin
        if (w_cand[0])      w_pick = 2'd0;
        else if (w_cand[1]) w_pick = 2'd2;
        else if (w_cand[2]) w_pick = 2'd3;
      end
    endcase
  end

  always_comb begin
    w_state_next  = r_state;
    w_owner_next  = r_owner;
    w_rr_ptr_next = r_rr_ptr;
    w_cnt_next    = r_cnt;
    w_switch_next = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_next  = OWN;
          w_owner_next  = w_pick;
          w_rr_ptr_next = succ(w_pick);
          w_cnt_next    = '0;
          w_switch_next = 1'b1;
        end
      end
      default: begin
        if (!req_i[r_owner]) begin
          w_switch_next = 1'b1;
          w_cnt_next    = '0;
          if (w_found) begin
            w_owner_next  = w_pick;
            w_rr_ptr_next = succ(w_pick);
          end else begin
            w_state_next = IDLE;
            w_owner_next = 2'd1;
          end
        end else if (r_cnt == CNT_MAX && w_found) begin
          w_owner_next  = w_pick;
          w_rr_ptr_next = succ(w_pick);
          w_cnt_next    = '0;
          w_switch_next = 1'b1;
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
    endcase
    w_grant_next = 4'b0001 << w_owner_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_grant  <= 4'b0010;
      r_owner  <= 2'd1;
      r_rr_ptr <= 2'd0;
      r_cnt    <= '0;
      r_switch <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_grant  <= w_grant_next;
      r_owner  <= w_owner_next;
      r_rr_ptr <= w_rr_ptr_next;
      r_cnt    <= w_cnt_next;
      r_switch <= w_switch_next;
    end
  end

  assign grant_o  = r_grant;
  assign owner_o  = r_owner;
  assign switch_o = r_switch;
  assign hold_o   = (r_state == OWN) | req_i[0] | req_i[2] | req_i[3];

endmodule

// File: tb/tb_xbus_arbiter.sv
// Randomized scoreboard bench for xbus_arbiter against a cycle-level ownership model.
module tb_xbus_arbiter;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b1111;
  logic [3:0] grant;
  logic [1:0] owner;
  logic       hold;
  logic       sw;

  xbus_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req),
    .grant_o  (grant),
    .owner_o  (owner),
    .hold_o   (hold),
    .switch_o (sw)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] grant;
    logic [1:0] owner;
    logic       hold;
    logic       sw;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Model: owner 1 means parked; age counts cycles the owner has held the bus.
  int   m_owner  = 1;
  int   m_age    = 0;
  int   m_ptr    = 0;
  bit   m_sw     = 0;
  logic       cur_rst = 1'b1;
  logic [3:0] cur_req = 4'b1111;
  int   order[3] = '{0, 2, 3};

  function automatic int next_in_rr(input logic [3:0] r, input int excl, input int ptr);
    int start;
    start = (ptr == 0) ? 0 : ptr - 1;
    for (int i = 0; i < 3; i++) begin
      int k;
      k = order[(start + i) % 3];
      if (r[k] && k != excl) return k;
    end
    return -1;
  endfunction

  task automatic give(input int k);
    m_owner = k;
    m_age   = 1;
    m_ptr   = order[((k == 0 ? 0 : k - 1) + 1) % 3];
    m_sw    = 1;
  endtask

  task automatic model_edge(input logic r, input logic [3:0] q);
    int k;
    m_sw = 0;
    if (r) begin
      m_owner = 1; m_age = 0; m_ptr = 0;
    end else if (m_owner == 1) begin
      k = next_in_rr(q, -1, m_ptr);
      if (k >= 0) give(k);
    end else if (!q[m_owner]) begin
      k = next_in_rr(q, m_owner, m_ptr);
      if (k >= 0) give(k);
      else begin
        m_owner = 1; m_age = 0; m_sw = 1;
      end
    end else begin
      k = next_in_rr(q, m_owner, m_ptr);
      if (m_age >= MAX_HOLD && k >= 0) give(k);
      else m_age++;
    end
  endtask

  task automatic step(input logic r, input logic [3:0] q);
    exp_t e;
    @(posedge clk);
    model_edge(cur_rst, cur_req);
    #1;
    rst = r; req = q;
    cur_rst = r; cur_req = q;
    cyc++;
    e.grant = 4'(1 << m_owner);
    e.owner = 2'(m_owner);
    e.hold  = (m_owner != 1) || q[0] || q[2] || q[3];
    e.sw    = m_sw;
    e.cyc   = cyc;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input int c, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, c, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("grant",  e.cyc, int'(grant), int'(e.grant));
        chk("owner",  e.cyc, int'(owner), int'(e.owner));
        chk("hold",   e.cyc, int'(hold),  int'(e.hold));
        chk("switch", e.cyc, int'(sw),    int'(e.sw));
        $display("cyc=%0d req=%b grant=%b owner=%0d hold=%b switch=%b",
                 e.cyc, req, grant, owner, hold, sw);
      end
    end
  end

  initial begin : stimulus
    logic [3:0] q;
    step(1, 4'b1111); step(1, 4'b1111);
    repeat (3) step(0, 4'b0000);
    repeat (3) step(0, 4'b0001);
    repeat (3) step(0, 4'b0000);
    repeat (40) step(0, 4'b1101);
    repeat (2) step(0, 4'b0000);
    step(0, 4'b0100);
    repeat (3) step(0, 4'b1100);
    repeat (3) step(0, 4'b1000);
    repeat (2) step(0, 4'b0000);
    repeat (20) step(0, 4'b0100);
    step(0, 4'b0000);
    repeat (6) step(0, 4'b1000);
    step(1, 4'b1000);
    repeat (4) step(0, 4'b1001);
    step(0, 4'b0000);
    // Owner drops for one cycle then re-raises while alone.
    step(0, 4'b0001); step(0, 4'b0001); step(0, 4'b0000);
    repeat (3) step(0, 4'b0001);
    q = 4'b0000;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(7) == 0) q[b] = ~q[b];
      end
      step(($urandom_range(199) == 0) ? 1'b1 : 1'b0, q);
    end
    step(0, 4'b0000);
    @(negedge clk);
    #1;
    chk("drain", cyc, sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
